// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: fetch-state encoding,
// the IF/ID record and fetch constants.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_STEP   = 4;

    typedef enum logic [1:0] {
        StReq,
        StHold,
        StDrain
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: asynchronous active-low reset, then load has
// priority over increment, otherwise the value holds.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    parameter int unsigned STEP      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        inc,
    output logic [31:0] pc
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc <= RESET_VAL;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register: PC, variable-latency imem
// handshake, one-entry stall hold buffer and redirect/flush handling.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned PC_STEP  = cpu_pkg::PC_STEP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pending_q, pending_d;
    ifid_t        hold_q, hold_d;
    ifid_t        ifid_q, ifid_d;
    ifid_t        new_word;
    logic         word_ok;

    logic         pc_load;
    logic         pc_inc;
    logic [31:0]  pc_load_val;
    logic [31:0]  pc;

    pc_reg #(
        .RESET_VAL (PC_RESET),
        .STEP      (PC_STEP)
    ) u_pc_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (pc_load),
        .load_pc (pc_load_val),
        .inc     (pc_inc),
        .pc      (pc)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        hold_d      = hold_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load_val = redirect_pc_i;
        imem_req_o  = 1'b0;
        word_ok     = 1'b0;
        new_word    = '{instr: imem_data_i, pc_plus4: pc + PC_STEP, valid: 1'b1};

        case (state_q)
            StReq: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    if (imem_ready_i) begin
                        pc_load = 1'b1;
                    end else begin
                        // Address must stay put until memory answers.
                        pending_d = redirect_pc_i;
                        state_d   = StDrain;
                    end
                end else if (imem_ready_i) begin
                    pc_inc = 1'b1;
                    if (stall_i) begin
                        hold_d  = new_word;
                        state_d = StHold;
                    end else begin
                        word_ok = 1'b1;
                    end
                end
            end
            StHold: begin
                if (redirect_i) begin
                    pc_load = 1'b1;
                    hold_d  = '0;
                    state_d = StReq;
                end else if (!stall_i) begin
                    new_word = hold_q;
                    word_ok  = 1'b1;
                    hold_d   = '0;
                    state_d  = StReq;
                end
            end
            StDrain: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    pending_d = redirect_pc_i;
                end
                if (imem_ready_i) begin
                    pc_load     = 1'b1;
                    pc_load_val = redirect_i ? redirect_pc_i : pending_q;
                    state_d     = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // IF/ID priority: flush, then stall, then a fetched word, else a bubble.
    always_comb begin
        ifid_d = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
        if (flush_i) begin
            ifid_d = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
        end else if (stall_i) begin
            ifid_d = ifid_q;
        end else if (word_ok) begin
            ifid_d = new_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StReq;
            pending_q <= 32'h0;
            hold_q    <= '0;
            ifid_q    <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            ifid_q    <= ifid_d;
        end
    end

    assign imem_addr_o = pc;
    assign pc_o        = pc;
    assign instr_o     = ifid_q.instr;
    assign pc_plus4_o  = ifid_q.pc_plus4;
    assign valid_o     = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stimulus against a
// transaction-level fetch model.
module tb_if_stage;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_ready_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o, instr_o, pc_plus4_o;
    logic        valid_o;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_data, w_pc, w_instr, w_pc4;

    always #5 clk_i = ~clk_i;

    assign imem_data_i = mem_word(imem_addr_o);
    assign w_data      = mem_word(w_addr);

    if_stage #(.PC_RESET(32'h0000_0000), .PC_STEP(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
        .imem_ready_i(imem_ready_i), .pc_o(pc_o), .instr_o(instr_o),
        .pc_plus4_o(pc_plus4_o), .valid_o(valid_o)
    );

    if_stage #(.PC_RESET(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(1'b0), .flush_i(1'b0),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_data_i(w_data),
        .imem_ready_i(1'b1), .pc_o(w_pc), .instr_o(w_instr),
        .pc_plus4_o(w_pc4), .valid_o(w_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: fetch pointer, optional deferred redirect target,
    // a queue of words fetched under stall, and the IF/ID contents.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } word_t;

    logic [31:0] m_pc;
    bit          m_wait_target;
    logic [31:0] m_target;
    word_t       m_buf[$];
    logic [31:0] m_instr, m_pc4;
    logic        m_valid;

    logic        last_req;
    logic [31:0] last_addr;

    task automatic model_reset();
        m_pc = 32'h0; m_wait_target = 0; m_target = 32'h0; m_buf.delete();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic fl, input logic rd,
                              input logic [31:0] rpc, input logic rdy);
        bit    got;
        word_t w;
        got = 0;
        w.instr = 32'h0; w.pc4 = 32'h0;
        if (m_buf.size() != 0) begin
            if (rd) begin
                m_buf.delete();
                m_pc = rpc;
            end else if (!st) begin
                w = m_buf.pop_front();
                got = 1;
            end
        end else if (m_wait_target) begin
            if (rd) m_target = rpc;
            if (rdy) begin
                m_pc = m_target;
                m_wait_target = 0;
            end
        end else if (rd) begin
            if (rdy) m_pc = rpc;
            else begin
                m_wait_target = 1;
                m_target = rpc;
            end
        end else if (rdy) begin
            w.instr = mem_word(m_pc);
            w.pc4 = m_pc + 32'd4;
            if (st) m_buf.push_back(w);
            else got = 1;
            m_pc = m_pc + 32'd4;
        end
        if (fl) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            if (got) begin
                m_instr = w.instr; m_pc4 = w.pc4; m_valid = 1'b1;
            end else begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end
        end
    endtask

    task automatic drive_cycle(input logic st, input logic fl, input logic rd,
                               input logic [31:0] rpc, input logic rdy);
        logic exp_req;
        @(negedge clk_i);
        stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = rpc;
        imem_ready_i = rdy;
        #1;
        last_req = imem_req_o;
        last_addr = imem_addr_o;
        exp_req = (m_buf.size() == 0);
        checks++;
        if (imem_req_o !== exp_req) begin
            errors++;
            $display("FAIL req: got %b expected %b", imem_req_o, exp_req);
        end
        checks++;
        if (pc_o !== m_pc) begin
            errors++;
            $display("FAIL pc: got %h expected %h", pc_o, m_pc);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr_o !== m_pc) begin
                errors++;
                $display("FAIL addr: got %h expected %h", imem_addr_o, m_pc);
            end
        end
        @(posedge clk_i);
        model_step(st, fl, rd, rpc, rdy);
        #1;
        checks++;
        if (instr_o !== m_instr || pc_plus4_o !== m_pc4 || valid_o !== m_valid) begin
            errors++;
            $display("FAIL ifid: got %h/%h/%b expected %h/%h/%b", instr_o, pc_plus4_o,
                     valid_o, m_instr, m_pc4, m_valid);
        end
    endtask

    task automatic do_reset();
        stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 32'h0; imem_ready_i = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        model_reset();
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        stall_i = 0; flush_i = 0; redirect_i = 0; imem_ready_i = 1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (instr_o !== 32'h0 || pc_plus4_o !== 32'h0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ifid: got %h/%h/%b expected 0/0/0", instr_o, pc_plus4_o,
                     valid_o);
        end
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_fetch: got req %b addr %h pc %h expected 1/0/0",
                     imem_req_o, imem_addr_o, pc_o);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, 0, 32'h0, 1);
            checks++;
            if (last_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_addr: got %h expected %h", last_addr, 32'(4 * i));
            end
            checks++;
            if (valid_o !== 1'b1 || pc_plus4_o !== 32'(4 * (i + 1)) ||
                instr_o !== mem_word(32'(4 * i))) begin
                errors++;
                $display("FAIL stream_ifid: got %h/%h/%b expected %h/%h/1", instr_o,
                         pc_plus4_o, valid_o, mem_word(32'(4 * i)), 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        drive_cycle(0, 0, 0, 32'h0, 1);
        for (int k = 0; k < 2; k++) begin
            drive_cycle(0, 0, 0, 32'h0, 0);
            checks++;
            if (last_addr !== 32'h4 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL wait_cycle: got addr %h valid %b expected 4/0", last_addr,
                         valid_o);
            end
        end
        drive_cycle(0, 0, 0, 32'h0, 1);
        checks++;
        if (last_addr !== 32'h4 || instr_o !== mem_word(32'h4) || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: got addr %h instr %h expected 4/%h", last_addr,
                     instr_o, mem_word(32'h4));
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        repeat (2) drive_cycle(0, 0, 0, 32'h0, 1);
        drive_cycle(1, 0, 0, 32'h0, 1);
        checks++;
        if (last_addr !== 32'h8 || instr_o !== mem_word(32'h4)) begin
            errors++;
            $display("FAIL stall_capture: got addr %h instr %h expected 8/%h", last_addr,
                     instr_o, mem_word(32'h4));
        end
        repeat (2) begin
            drive_cycle(1, 0, 0, 32'h0, 1);
            checks++;
            if (last_req !== 1'b0 || instr_o !== mem_word(32'h4) || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: got req %b instr %h expected 0/%h", last_req,
                         instr_o, mem_word(32'h4));
            end
        end
        drive_cycle(0, 0, 0, 32'h0, 0);
        checks++;
        if (instr_o !== mem_word(32'h8) || pc_plus4_o !== 32'hC || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got %h/%h expected %h/c", instr_o, pc_plus4_o,
                     mem_word(32'h8));
        end
        drive_cycle(0, 0, 0, 32'h0, 1);
        checks++;
        if (last_addr !== 32'hC || instr_o !== mem_word(32'hC)) begin
            errors++;
            $display("FAIL stall_resume: got addr %h instr %h expected c/%h", last_addr,
                     instr_o, mem_word(32'hC));
        end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        repeat (4) drive_cycle(0, 0, 0, 32'h0, 1);
        drive_cycle(0, 1, 1, 32'h100, 0);
        drive_cycle(0, 0, 0, 32'h0, 0);
        checks++;
        if (last_addr !== 32'h10 || last_req !== 1'b1) begin
            errors++;
            $display("FAIL drain_addr: got %h req %b expected 10/1", last_addr, last_req);
        end
        drive_cycle(0, 0, 0, 32'h0, 1);
        checks++;
        if (last_addr !== 32'h10 || valid_o !== 1'b0 || instr_o === mem_word(32'h10)) begin
            errors++;
            $display("FAIL drain_discard: got addr %h instr %h valid %b", last_addr,
                     instr_o, valid_o);
        end
        drive_cycle(0, 0, 0, 32'h0, 1);
        checks++;
        if (last_addr !== 32'h100 || instr_o !== mem_word(32'h100) || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_target: got addr %h instr %h expected 100/%h", last_addr,
                     instr_o, mem_word(32'h100));
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        repeat (2) drive_cycle(0, 0, 0, 32'h0, 1);
        drive_cycle(1, 1, 0, 32'h0, 0);
        checks++;
        if (instr_o !== 32'h0 || pc_plus4_o !== 32'h0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %h/%h/%b expected 0/0/0", instr_o, pc_plus4_o,
                     valid_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk_i);
        checks++;
        if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap_first_addr: got %h expected fffffffc", w_addr);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (w_pc4 !== 32'h0 || w_valid !== 1'b1 || w_instr !== mem_word(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_pc4: got %h valid %b expected 0/1", w_pc4, w_valid);
        end
        @(negedge clk_i);
        checks++;
        if (w_addr !== 32'h0 || w_pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next_addr: got %h expected 0", w_addr);
        end
    endtask

    task automatic test_random();
        logic        st, fl, rd, rdy;
        logic [31:0] rpc;
        do_reset();
        repeat (400) begin
            st  = ($urandom % 4) == 0;
            rd  = ($urandom % 8) == 0;
            fl  = rd | (($urandom % 32) == 0);
            rdy = ($urandom % 2) == 0;
            rpc = (($urandom % 16) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            drive_cycle(st, fl, rd, rpc, rdy);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_wait_states();
        test_stall_hold();
        test_redirect_drain();
        test_flush_stall();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
